// File: rtl/axi_sram_slave.sv
`default_nettype none
// ============================================================================
//  Module   : axi_sram_slave
//  Purpose  : AXI4 slave port terminating on a single-port synchronous SRAM
//             (1-cycle read latency, active-low controls). Serves one
//             transaction at a time: a read burst, or a write burst followed
//             by its response. Reads win over writes when both are offered.
//  Ports    : clk, rst_n          - clock, synchronous active-low reset
//             AW*_S / W*_S / B*_S - AXI write address / data / response
//             AR*_S / R*_S        - AXI read address / data
//             CEB, WEB, BWEB      - SRAM chip enable, write enable, bit mask
//             A, DI, DO           - SRAM word address, write data, read data
//  Revision : 1.0 - initial release
// ============================================================================
module axi_sram_slave #(
    parameter int ID_WIDTH   = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 4,
    parameter int MEM_AW     = 14
) (
    input  logic                    clk,
    input  logic                    rst_n,
    // write address channel
    input  logic [ID_WIDTH-1:0]     AWID_S,
    input  logic [ADDR_WIDTH-1:0]   AWADDR_S,
    input  logic [LEN_WIDTH-1:0]    AWLEN_S,
    input  logic [2:0]              AWSIZE_S,
    input  logic [1:0]              AWBURST_S,
    input  logic                    AWVALID_S,
    output logic                    AWREADY_S,
    // write data channel
    input  logic [DATA_WIDTH-1:0]   WDATA_S,
    input  logic [DATA_WIDTH/8-1:0] WSTRB_S,
    input  logic                    WLAST_S,
    input  logic                    WVALID_S,
    output logic                    WREADY_S,
    // write response channel
    output logic [ID_WIDTH-1:0]     BID_S,
    output logic [1:0]              BRESP_S,
    output logic                    BVALID_S,
    input  logic                    BREADY_S,
    // read address channel
    input  logic [ID_WIDTH-1:0]     ARID_S,
    input  logic [ADDR_WIDTH-1:0]   ARADDR_S,
    input  logic [LEN_WIDTH-1:0]    ARLEN_S,
    input  logic [2:0]              ARSIZE_S,
    input  logic [1:0]              ARBURST_S,
    input  logic                    ARVALID_S,
    output logic                    ARREADY_S,
    // read data channel
    output logic [ID_WIDTH-1:0]     RID_S,
    output logic [DATA_WIDTH-1:0]   RDATA_S,
    output logic [1:0]              RRESP_S,
    output logic                    RLAST_S,
    output logic                    RVALID_S,
    input  logic                    RREADY_S,
    // SRAM macro
    output logic                    CEB,
    output logic                    WEB,
    output logic [DATA_WIDTH-1:0]   BWEB,
    output logic [MEM_AW-1:0]       A,
    output logic [DATA_WIDTH-1:0]   DI,
    input  logic [DATA_WIDTH-1:0]   DO
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_WB   = 2'd3;

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic [ID_WIDTH-1:0]   r_id;
    logic [MEM_AW-1:0]     r_addr;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_cnt;

    logic                  w_ar_rdy;
    logic                  w_aw_rdy;
    logic                  w_rd_vld;
    logic                  w_wr_rdy;
    logic                  w_wb_vld;
    logic                  w_ar_hs;
    logic                  w_aw_hs;
    logic                  w_r_hs;
    logic                  w_w_hs;
    logic                  w_b_hs;
    logic                  w_last;
    logic [DATA_WIDTH-1:0] w_strb_bits;

    // Burst type, beat size, WLAST and the address bits outside the SRAM
    // word range have no effect on this slave.
    logic w_unused;
    assign w_unused = ^{AWSIZE_S, AWBURST_S, ARSIZE_S, ARBURST_S, WLAST_S,
                        AWADDR_S, ARADDR_S};

    // Channel qualifiers are masked by rst_n so nothing can handshake while
    // reset is being applied, even before the state register has cleared.
    assign w_ar_rdy = rst_n && (r_state == S_IDLE);
    assign w_aw_rdy = w_ar_rdy && !ARVALID_S;      // read has priority
    assign w_rd_vld = rst_n && (r_state == S_RD);
    assign w_wr_rdy = rst_n && (r_state == S_WR);
    assign w_wb_vld = rst_n && (r_state == S_WB);

    assign w_ar_hs = ARVALID_S && w_ar_rdy;
    assign w_aw_hs = AWVALID_S && w_aw_rdy;
    assign w_r_hs  = w_rd_vld && RREADY_S;
    assign w_w_hs  = w_wr_rdy && WVALID_S;
    assign w_b_hs  = w_wb_vld && BREADY_S;
    assign w_last  = (r_cnt == r_len);

    // Byte strobes expanded to one bit per data bit.
    generate
        for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_strb_bits
            assign w_strb_bits[gi] = WSTRB_S[gi/8];
        end
    endgenerate

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_ar_hs) begin
                    w_state_next = S_RD;
                end else if (w_aw_hs) begin
                    w_state_next = S_WR;
                end
            end
            S_RD: begin
                if (w_r_hs && w_last) begin
                    w_state_next = S_IDLE;
                end
            end
            S_WR: begin
                // The beat count, not WLAST, ends the burst.
                if (w_w_hs && w_last) begin
                    w_state_next = S_WB;
                end
            end
            S_WB: begin
                if (w_b_hs) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        AWREADY_S = 1'b0;
        ARREADY_S = 1'b0;
        WREADY_S  = 1'b0;
        BVALID_S  = 1'b0;
        BID_S     = '0;
        BRESP_S   = 2'b00;
        RVALID_S  = 1'b0;
        RID_S     = '0;
        RDATA_S   = '0;
        RRESP_S   = 2'b00;
        RLAST_S   = 1'b0;
        CEB       = 1'b1;
        WEB       = 1'b1;
        BWEB      = '1;
        A         = '0;
        DI        = '0;
        case (r_state)
            S_IDLE: begin
                ARREADY_S = w_ar_rdy;
                AWREADY_S = w_aw_rdy;
                // Issue the first read immediately so data is ready next cycle.
                if (w_ar_hs) begin
                    CEB = 1'b0;
                    A   = ARADDR_S[MEM_AW+1:2];
                end
            end
            S_RD: begin
                RVALID_S = w_rd_vld;
                RID_S    = r_id;
                RDATA_S  = DO;
                RLAST_S  = w_rd_vld && w_last;
                // Read ahead when the beat is consumed; otherwise re-read the
                // current word so DO stays stable under back-pressure.
                CEB = 1'b0;
                A   = RREADY_S ? (r_addr + 1'b1) : r_addr;
            end
            S_WR: begin
                WREADY_S = w_wr_rdy;
                if (w_w_hs) begin
                    CEB  = 1'b0;
                    WEB  = 1'b0;
                    A    = r_addr;
                    DI   = WDATA_S;
                    BWEB = ~w_strb_bits;
                end
            end
            S_WB: begin
                BVALID_S = w_wb_vld;
                BID_S    = r_id;
            end
            default: ;
        endcase
    end

    // ---------------- transaction registers ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_id   <= '0;
            r_addr <= '0;
            r_len  <= '0;
            r_cnt  <= '0;
        end else if (w_ar_hs) begin
            r_id   <= ARID_S;
            r_len  <= ARLEN_S;
            r_addr <= ARADDR_S[MEM_AW+1:2];
            r_cnt  <= '0;
        end else if (w_aw_hs) begin
            r_id   <= AWID_S;
            r_len  <= AWLEN_S;
            r_addr <= AWADDR_S[MEM_AW+1:2];
            r_cnt  <= '0;
        end else if (w_r_hs || w_w_hs) begin
            // Word address wraps modulo the SRAM depth.
            r_addr <= r_addr + 1'b1;
            r_cnt  <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_sram_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_sram_slave
//  Purpose  : Self-checking bench for axi_sram_slave with a behavioural
//             SRAM model and an R/B response scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi_sram_slave;

    localparam int ID_WIDTH   = 8;
    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int LEN_WIDTH  = 4;
    localparam int MEM_AW     = 14;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [ID_WIDTH-1:0]   AWID_S, ARID_S, BID_S, RID_S;
    logic [ADDR_WIDTH-1:0] AWADDR_S, ARADDR_S;
    logic [LEN_WIDTH-1:0]  AWLEN_S, ARLEN_S;
    logic [2:0]            AWSIZE_S, ARSIZE_S;
    logic [1:0]            AWBURST_S, ARBURST_S, BRESP_S, RRESP_S;
    logic                  AWVALID_S, AWREADY_S, ARVALID_S, ARREADY_S;
    logic [DATA_WIDTH-1:0] WDATA_S, RDATA_S;
    logic [3:0]            WSTRB_S;
    logic                  WLAST_S, WVALID_S, WREADY_S;
    logic                  BVALID_S, BREADY_S;
    logic                  RLAST_S, RVALID_S, RREADY_S;
    logic                  CEB, WEB;
    logic [DATA_WIDTH-1:0] BWEB, DI;
    logic [DATA_WIDTH-1:0] DO = '0;
    logic [MEM_AW-1:0]     A;

    always #5 clk = ~clk;

    axi_sram_slave #(
        .ID_WIDTH(ID_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
        .LEN_WIDTH(LEN_WIDTH), .MEM_AW(MEM_AW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .AWID_S(AWID_S), .AWADDR_S(AWADDR_S), .AWLEN_S(AWLEN_S),
        .AWSIZE_S(AWSIZE_S), .AWBURST_S(AWBURST_S), .AWVALID_S(AWVALID_S),
        .AWREADY_S(AWREADY_S),
        .WDATA_S(WDATA_S), .WSTRB_S(WSTRB_S), .WLAST_S(WLAST_S),
        .WVALID_S(WVALID_S), .WREADY_S(WREADY_S),
        .BID_S(BID_S), .BRESP_S(BRESP_S), .BVALID_S(BVALID_S), .BREADY_S(BREADY_S),
        .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S),
        .ARSIZE_S(ARSIZE_S), .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S),
        .ARREADY_S(ARREADY_S),
        .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S),
        .RVALID_S(RVALID_S), .RREADY_S(RREADY_S),
        .CEB(CEB), .WEB(WEB), .BWEB(BWEB), .A(A), .DI(DI), .DO(DO)
    );

    // ---------------- SRAM model (1-cycle read latency) ----------------
    logic [31:0] mem [0:(1<<MEM_AW)-1];
    logic        preload_en;

    always @(posedge clk) begin
        if (preload_en) begin
            mem[14'h010] <= 32'hDEADBEEF;
            mem[14'h040] <= 32'hC0DE0040;
            mem[14'h041] <= 32'hC0DE0041;
            mem[14'h042] <= 32'hC0DE0042;
            mem[14'h043] <= 32'hC0DE0043;
        end else if (!CEB) begin
            if (!WEB) mem[A] <= (mem[A] & BWEB) | (DI & ~BWEB);
            else      DO     <= mem[A];
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [7:0]  id;
        logic [31:0] data;
        logic        last;
    } r_exp_t;

    r_exp_t     r_q[$];
    logic [7:0] b_q[$];
    r_exp_t     r_e;
    int         checks = 0;
    int         errors = 0;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (RVALID_S) begin
                checks++;
                if (r_q.size() == 0) begin
                    errors++;
                    $display("FAIL r_unexpected: RDATA=%h RID=%h with no beat expected", RDATA_S, RID_S);
                end else begin
                    r_e = r_q[0];
                    if ({RID_S, RDATA_S, RLAST_S, RRESP_S} !== {r_e.id, r_e.data, r_e.last, 2'b00}) begin
                        errors++;
                        $display("FAIL %s: got id=%h data=%h last=%b resp=%b, expected id=%h data=%h last=%b resp=00",
                                 RREADY_S ? "r_beat" : "r_stall", RID_S, RDATA_S, RLAST_S, RRESP_S,
                                 r_e.id, r_e.data, r_e.last);
                    end
                    if (RREADY_S) void'(r_q.pop_front());
                end
            end
            if (BVALID_S && BREADY_S) begin
                checks++;
                if (b_q.size() == 0) begin
                    errors++;
                    $display("FAIL b_unexpected: BID=%h with no response expected", BID_S);
                end else begin
                    if ({BID_S, BRESP_S} !== {b_q[0], 2'b00}) begin
                        errors++;
                        $display("FAIL b_resp: got id=%h resp=%b, expected id=%h resp=00",
                                 BID_S, BRESP_S, b_q[0]);
                    end
                    void'(b_q.pop_front());
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    logic        rr_pat   [0:15];
    int          rr_len;
    logic [31:0] exp_words[0:15];
    logic [31:0] w_words  [0:15];
    logic [3:0]  w_strbs  [0:15];
    logic        w_lasts  [0:15];

    task automatic issue_ar(input logic [7:0] id, input logic [31:0] addr,
                            input int len, output bit ok);
        int n;
        ARID_S = id; ARADDR_S = addr; ARLEN_S = len[3:0];
        ARSIZE_S = 3'd2; ARBURST_S = 2'b01; ARVALID_S = 1'b1;
        ok = 1'b0; n = 0;
        while (!ok && n < 20) begin
            @(negedge clk);
            if (ARREADY_S) ok = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        ARVALID_S = 1'b0;
        check("ar_accept", {63'd0, ok}, 64'd1);
    endtask

    task automatic do_read(input logic [7:0] id, input logic [31:0] addr, input int len);
        bit ok;
        bit done;
        int k;
        issue_ar(id, addr, len, ok);
        if (ok) begin
            for (int i = 0; i <= len; i++) r_q.push_back(r_exp_t'{id, exp_words[i], (i == len)});
            k = 0; done = 1'b0;
            while (!done && k < 64) begin
                RREADY_S = rr_pat[k % rr_len];
                @(negedge clk);
                if (k == 0) check("r_first_valid", {63'd0, RVALID_S}, 64'd1);
                if (RVALID_S && RREADY_S && RLAST_S) done = 1'b1;
                @(posedge clk); #1;
                k++;
            end
            RREADY_S = 1'b0;
            check("r_burst_done", {63'd0, done}, 64'd1);
        end
    endtask

    task automatic do_write(input logic [7:0] id, input logic [31:0] addr,
                            input int len, output int aw_wait);
        bit ok;
        int n;
        int beat;
        AWID_S = id; AWADDR_S = addr; AWLEN_S = len[3:0];
        AWSIZE_S = 3'd2; AWBURST_S = 2'b01; AWVALID_S = 1'b1;
        ok = 1'b0; n = 0; aw_wait = 0;
        while (!ok && n < 20) begin
            @(negedge clk);
            if (AWREADY_S) ok = 1'b1; else aw_wait++;
            @(posedge clk); #1;
            n++;
        end
        AWVALID_S = 1'b0;
        check("aw_accept", {63'd0, ok}, 64'd1);
        if (ok) begin
            b_q.push_back(id);
            beat = 0; n = 0;
            while (beat <= len && n < 64) begin
                WDATA_S = w_words[beat]; WSTRB_S = w_strbs[beat];
                WLAST_S = w_lasts[beat]; WVALID_S = 1'b1;
                @(negedge clk);
                if (n == 0) check("w_ready_first", {63'd0, WREADY_S}, 64'd1);
                if (WREADY_S) beat++;
                @(posedge clk); #1;
                n++;
            end
            WVALID_S = 1'b0; WLAST_S = 1'b0;
            check("w_beats_done", beat, len + 1);
            // Response must be up in the cycle right after the last beat.
            BREADY_S = 1'b1;
            @(negedge clk);
            check("b_valid_timing", {63'd0, BVALID_S}, 64'd1);
            check("w_ready_after_last", {63'd0, WREADY_S}, 64'd0);
            @(posedge clk); #1;
            BREADY_S = 1'b0;
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int  aw_wait;
        bit  ok;
        int  n;
        rst_n = 1'b0; preload_en = 1'b1;
        AWID_S = '0; AWADDR_S = '0; AWLEN_S = '0; AWSIZE_S = '0; AWBURST_S = '0;
        ARID_S = '0; ARADDR_S = '0; ARLEN_S = '0; ARSIZE_S = '0; ARBURST_S = '0;
        WDATA_S = '0; WSTRB_S = '0; WLAST_S = 1'b0; WVALID_S = 1'b0;
        BREADY_S = 1'b0; RREADY_S = 1'b0;
        // Offer both address channels during reset: neither may be accepted.
        ARVALID_S = 1'b1; AWVALID_S = 1'b1;
        repeat (3) @(posedge clk);
        #1 preload_en = 1'b0;

        @(negedge clk);
        check("rst_arready", {63'd0, ARREADY_S}, 64'd0);
        check("rst_awready", {63'd0, AWREADY_S}, 64'd0);
        check("rst_valids", {60'd0, RVALID_S, BVALID_S, WREADY_S, RLAST_S}, 64'd0);
        check("rst_ids_resps", {44'd0, RID_S, BID_S, RRESP_S, BRESP_S}, 64'd0);
        @(posedge clk); #1;
        ARVALID_S = 1'b0; AWVALID_S = 1'b0; rst_n = 1'b1;

        @(negedge clk);
        check("idle_readies", {62'd0, ARREADY_S, AWREADY_S}, 64'd3);
        check("idle_ceb_web", {62'd0, CEB, WEB}, 64'd3);
        check("idle_bweb", {32'd0, BWEB}, 64'hFFFF_FFFF);
        check("idle_a_di", {18'd0, A, DI}, 64'd0);
        @(posedge clk); #1;

        // Single read of preloaded word 0x10.
        rr_pat[0] = 1'b1; rr_len = 1;
        exp_words[0] = 32'hDEADBEEF;
        do_read(8'h15, 32'h0000_0040, 0);

        // Four-beat read with back-pressure.
        rr_pat[0] = 1'b1; rr_pat[1] = 1'b0; rr_pat[2] = 1'b0; rr_pat[3] = 1'b1;
        rr_pat[4] = 1'b1; rr_pat[5] = 1'b0; rr_pat[6] = 1'b1; rr_len = 7;
        exp_words[0] = 32'hC0DE0040; exp_words[1] = 32'hC0DE0041;
        exp_words[2] = 32'hC0DE0042; exp_words[3] = 32'hC0DE0043;
        do_read(8'h2A, 32'h0000_0100, 3);

        // Partial-strobe write over 0xDEADBEEF, then read back.
        w_words[0] = 32'h11223344; w_strbs[0] = 4'b0101; w_lasts[0] = 1'b1;
        do_write(8'h3C, 32'h0000_0040, 0, aw_wait);
        check("aw_wait_idle", aw_wait, 0);
        rr_pat[0] = 1'b1; rr_len = 1;
        exp_words[0] = 32'hDE22BE44;
        do_read(8'h3D, 32'h0000_0040, 0);

        // Write burst from the top word, wrapping to 0; WLAST wrongly on beat 2.
        w_words[0] = 32'h0BAD0000; w_words[1] = 32'h0BAD0001;
        w_words[2] = 32'h0BAD0002; w_words[3] = 32'h0BAD0003;
        w_strbs[0] = 4'hF; w_strbs[1] = 4'hF; w_strbs[2] = 4'hF; w_strbs[3] = 4'hF;
        w_lasts[0] = 1'b0; w_lasts[1] = 1'b1; w_lasts[2] = 1'b0; w_lasts[3] = 1'b1;
        do_write(8'h47, 32'h0000_FFFC, 3, aw_wait);
        exp_words[0] = 32'h0BAD0000; exp_words[1] = 32'h0BAD0001;
        exp_words[2] = 32'h0BAD0002; exp_words[3] = 32'h0BAD0003;
        do_read(8'h48, 32'h0000_FFFC, 3);
        exp_words[0] = 32'h0BAD0001; exp_words[1] = 32'h0BAD0002;
        exp_words[2] = 32'h0BAD0003;
        do_read(8'h49, 32'h0000_0000, 2);

        // AR and AW together: read first, write accepted right after RLAST.
        AWID_S = 8'h5E; AWADDR_S = 32'h0000_0080; AWLEN_S = 4'd0;
        AWSIZE_S = 3'd2; AWBURST_S = 2'b01; AWVALID_S = 1'b1;
        ARID_S = 8'h21; ARADDR_S = 32'h0000_0100; ARLEN_S = 4'd0;
        ARSIZE_S = 3'd2; ARBURST_S = 2'b01; ARVALID_S = 1'b1;
        @(negedge clk);
        check("both_arready", {63'd0, ARREADY_S}, 64'd1);
        check("both_awready", {63'd0, AWREADY_S}, 64'd0);
        @(posedge clk); #1;
        ARVALID_S = 1'b0;
        r_q.push_back(r_exp_t'{8'h21, 32'hC0DE0040, 1'b1});
        RREADY_S = 1'b1;
        @(negedge clk);
        check("both_rvalid", {63'd0, RVALID_S}, 64'd1);
        check("both_awready_in_rd", {63'd0, AWREADY_S}, 64'd0);
        @(posedge clk); #1;
        RREADY_S = 1'b0;
        w_words[0] = 32'h5A5A5A5A; w_strbs[0] = 4'hF; w_lasts[0] = 1'b1;
        do_write(8'h5E, 32'h0000_0080, 0, aw_wait);
        check("aw_after_rlast", aw_wait, 0);
        rr_pat[0] = 1'b1; rr_len = 1;
        exp_words[0] = 32'h5A5A5A5A;
        do_read(8'h22, 32'h0000_0080, 0);

        // Reset after the second beat of a four-beat read.
        issue_ar(8'h63, 32'h0000_0100, 3, ok);
        r_q.push_back(r_exp_t'{8'h63, 32'hC0DE0040, 1'b0});
        r_q.push_back(r_exp_t'{8'h63, 32'hC0DE0041, 1'b0});
        RREADY_S = 1'b1;
        repeat (2) begin
            @(negedge clk);
            @(posedge clk); #1;
        end
        rst_n = 1'b0; RREADY_S = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_rvalid", {62'd0, RVALID_S, RLAST_S}, 64'd0);
        check("post_rst_idle", {62'd0, ARREADY_S, AWREADY_S}, 64'd3);
        @(posedge clk); #1;
        rr_pat[0] = 1'b1; rr_len = 1;
        exp_words[0] = 32'hDE22BE44;
        do_read(8'h15, 32'h0000_0040, 0);

        n = 0;
        while ((r_q.size() != 0 || b_q.size() != 0) && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("queues_drained", r_q.size() + b_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
